// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// sticky error bit positions and the per-opcode settle-latency selector.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOOP    = 4'd0;
    localparam logic [3:0] OP_RESET   = 4'd1;
    localparam logic [3:0] OP_PRESET  = 4'd2;
    localparam logic [3:0] OP_ILLEGAL = 4'd3;
    localparam logic [3:0] OP_ADD     = 4'd4;
    localparam logic [3:0] OP_SUB     = 4'd5;
    localparam logic [3:0] OP_MUL     = 4'd6;
    localparam logic [3:0] OP_DIV     = 4'd7;
    localparam logic [3:0] OP_MOD     = 4'd8;
    localparam logic [3:0] OP_AND     = 4'd9;
    localparam logic [3:0] OP_OR      = 4'd10;
    localparam logic [3:0] OP_XOR     = 4'd11;
    localparam logic [3:0] OP_NOT     = 4'd12;
    localparam logic [3:0] OP_NAND    = 4'd13;
    localparam logic [3:0] OP_NOR     = 4'd14;
    localparam logic [3:0] OP_XNOR    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ERR_OVF  = 0;
    localparam int ERR_DIV0 = 1;
    localparam int ERR_ILL  = 2;

    // Number of EXEC cycles the ALU inputs are held before writeback.
    function automatic logic [3:0] lat_sel(input logic [3:0] op,
                                           input logic [3:0] mul_lat,
                                           input logic [3:0] div_lat);
        logic [3:0] lat;
        case (op)
            OP_MUL:         lat = mul_lat;
            OP_DIV, OP_MOD: lat = div_lat;
            default:        lat = 4'd1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command-level controller for the 16-bit ALU datapath: accepts one command per
// handshake, holds ALU inputs for the settle time, then writes back the accumulator.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_ovf,
    output logic [15:0] acc,
    output logic [15:0] acc_hi,
    output logic        done,
    output logic        busy,
    output logic [2:0]  err
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_lat_chk
        $error("alu_sequencer: MUL_LAT must be within 1..15");
    end
    if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_div_lat_chk
        $error("alu_sequencer: DIV_LAT must be within 1..15");
    end

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] acc_hi_q, acc_hi_d;
    logic [2:0]  err_q, err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        wb_s;

    // Next-state, handshake and writeback computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_op_d = alu_op_q;
        acc_d    = acc_q;
        acc_hi_d = acc_hi_q;
        err_d    = err_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        wb_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_EXEC;
                    cnt_d    = lat_sel(cmd_op, MUL_LAT_C, DIV_LAT_C);
                    alu_a_d  = cmd_operand;
                    alu_op_d = cmd_op;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = ST_DONE;
                    alu_op_d = OP_NOOP;
                    done_d   = 1'b1;
                    wb_s     = 1'b1;
                end else begin
                    state_d  = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                alu_op_d = OP_NOOP;
                busy_d   = 1'b0;
            end
        endcase

        // alu_op_q still holds the executing opcode on the writeback edge.
        if (wb_s) begin
            case (alu_op_q)
                OP_NOOP: begin
                    acc_d = acc_q;
                end
                OP_RESET: begin
                    acc_d    = 16'd0;
                    acc_hi_d = 16'd0;
                    err_d    = 3'b000;
                end
                OP_PRESET: begin
                    acc_d    = 16'hFFFF;
                    acc_hi_d = 16'd0;
                end
                OP_ILLEGAL: begin
                    err_d[ERR_ILL] = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    acc_d    = alu_result[15:0];
                    acc_hi_d = 16'd0;
                    if (alu_ovf) begin
                        err_d[ERR_OVF] = 1'b1;
                    end else begin
                        err_d[ERR_OVF] = err_q[ERR_OVF];
                    end
                end
                OP_MUL: begin
                    acc_d    = alu_result[15:0];
                    acc_hi_d = alu_result[31:16];
                end
                OP_DIV, OP_MOD: begin
                    if (alu_a_q == 16'd0) begin
                        err_d[ERR_DIV0] = 1'b1;
                    end else begin
                        acc_d    = alu_result[15:0];
                        acc_hi_d = 16'd0;
                    end
                end
                default: begin
                    acc_d    = alu_result[15:0];
                    acc_hi_d = 16'd0;
                end
            endcase
        end else begin
            wb_s = 1'b0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            alu_a_q  <= 16'd0;
            alu_op_q <= 4'd0;
            acc_q    <= 16'd0;
            acc_hi_q <= 16'd0;
            err_q    <= 3'b000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_op_q <= alu_op_d;
            acc_q    <= acc_d;
            acc_hi_q <= acc_hi_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd_ready = ready_q & rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = acc_q;
    assign alu_op    = alu_op_q;
    assign acc       = acc_q;
    assign acc_hi    = acc_hi_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural ALU and
// a command-level reference model of the accumulator and sticky errors.
module tb_alu_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [15:0] cmd_operand = 16'd0;
    logic [15:0] alu_a, alu_b, acc, acc_hi;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_ovf;
    logic        done, busy;
    logic [2:0]  err;

    logic        ovf_force = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_l = 1;
    bit chain = 1'b0;

    logic [15:0] m_acc = 16'd0;
    logic [15:0] m_hi = 16'd0;
    logic [2:0]  m_err = 3'd0;

    typedef struct {
        logic [15:0] acc;
        logic [15:0] hi;
        logic [2:0]  err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .alu_ovf(alu_ovf), .acc(acc),
        .acc_hi(acc_hi), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: a is the operand, b the accumulator.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa, wb;
        wa = {16'd0, a};
        wb = {16'd0, b};
        case (op)
            4'd4:  return (wb + wa) & 32'h0000_FFFF;
            4'd5:  return (wb - wa) & 32'h0000_FFFF;
            4'd6:  return wb * wa;
            4'd7:  return (a == 16'd0) ? 32'd0 : wb / wa;
            4'd8:  return (a == 16'd0) ? 32'd0 : wb % wa;
            4'd9:  return {16'd0, b & a};
            4'd10: return {16'd0, b | a};
            4'd11: return {16'd0, b ^ a};
            4'd12: return {16'd0, ~b};
            4'd13: return {16'd0, ~(b & a)};
            4'd14: return {16'd0, ~(b | a)};
            4'd15: return {16'd0, ~(b ^ a)};
            default: return 32'd0;
        endcase
    endfunction

    // Signed overflow of acc+operand / acc-operand.
    function automatic logic ovf_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 4'd4) begin
            r = sb + sa;
            return (r > 32767) || (r < -32768);
        end
        if (op == 4'd5) begin
            r = sb - sa;
            return (r > 32767) || (r < -32768);
        end
        return 1'b0;
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd6) return MUL_LAT;
        if (op == 4'd7 || op == 4'd8) return DIV_LAT;
        return 1;
    endfunction

    always_comb begin
        alu_result = ovr_en ? ovr_val : alu_fn(alu_op, alu_a, alu_b);
        alu_ovf    = ovf_force | ovf_fn(alu_op, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("acc", {16'd0, acc}, {16'd0, e.acc});
                check("acc_hi", {16'd0, acc_hi}, {16'd0, e.hi});
                check("err", {29'd0, err}, {29'd0, e.err});
            end
        end
    end

    // Reference model at command level: apply the opcode's effect to acc/acc_hi/err.
    task automatic model(input logic [3:0] op, input logic [15:0] opnd, input logic fovf,
                         input logic oen, input logic [31:0] oval);
        logic [31:0] r;
        r = oen ? oval : alu_fn(op, opnd, m_acc);
        case (op)
            4'd0: ;
            4'd1: begin m_acc = 16'd0; m_hi = 16'd0; m_err = 3'd0; end
            4'd2: begin m_acc = 16'hFFFF; m_hi = 16'd0; end
            4'd3: m_err[2] = 1'b1;
            4'd4, 4'd5: begin
                if (fovf || ovf_fn(op, opnd, m_acc)) m_err[0] = 1'b1;
                m_acc = r[15:0]; m_hi = 16'd0;
            end
            4'd6: begin m_acc = r[15:0]; m_hi = r[31:16]; end
            4'd7, 4'd8: begin
                if (opnd == 16'd0) m_err[1] = 1'b1;
                else begin m_acc = r[15:0]; m_hi = 16'd0; end
            end
            default: begin m_acc = r[15:0]; m_hi = 16'd0; end
        endcase
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] opnd, input logic fovf,
                        input logic oen, input logic [31:0] oval, input bit b2b);
        int waits;
        int t;
        bit do_b2b;
        exp_t e;
        do_b2b = b2b && chain;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_operand = opnd;
        waits = 0;
        while (!cmd_ready && waits < 64) begin
            if (do_b2b) check("busy_while_not_ready", {31'd0, busy}, 32'd1);
            waits++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            chain = 1'b0;
            return;
        end
        if (do_b2b) check("b2b_accept_gap", waits, prev_l + 1);
        ovf_force = fovf;
        ovr_en = oen;
        ovr_val = oval;
        t = cyc + 1;
        model(op, opnd, fovf, oen, oval);
        e.acc = m_acc;
        e.hi = m_hi;
        e.err = m_err;
        e.cyc = t + lat_of(op);
        exp_q.push_back(e);
        prev_l = lat_of(op);
        @(posedge clk);
        chain = 1'b1;
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        cmd_valid = 1'b0;
        chain = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        ovr_en = 1'b0;
        ovf_force = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_acc"}, {16'd0, acc}, 32'd0);
        check({tag, "_acc_hi"}, {16'd0, acc_hi}, 32'd0);
        check({tag, "_err"}, {29'd0, err}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
        check({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
    endtask

    initial begin
        int gap;
        logic [3:0] rop;
        logic [15:0] ropnd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks("reset");
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);

        // ADD 12 onto acc=10
        send(4'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        send(4'd4, 16'd10, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd4, 16'd12, 1'b0, 1'b0, 32'd0, 1'b1);
        drain();

        // MUL 20*20 then a forced 32'h0001_0000 product
        send(4'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        send(4'd4, 16'd20, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd6, 16'd20, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd6, 16'd3, 1'b0, 1'b1, 32'h0001_0000, 1'b1);
        drain();

        // Divide by zero, NOOP keeps error, RESET clears
        send(4'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        send(4'd4, 16'd20, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd7, 16'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd0, 16'd55, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd8, 16'd7, 1'b0, 1'b0, 32'd0, 1'b1);

        // Overflow sticky, ignored on AND, illegal opcode
        send(4'd5, 16'd3, 1'b1, 1'b0, 32'd0, 1'b1);
        send(4'd9, 16'h0F0F, 1'b1, 1'b0, 32'd0, 1'b1);
        send(4'd3, 16'd9, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd2, 16'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd4, 16'd1, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd1, 16'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ropnd = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                chain = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
            send(rop, ropnd, ($urandom_range(0, 7) == 0), 1'b0, 32'd0, 1'b1);
        end
        drain();

        // Reset in the middle of a divide: no writeback, no done
        send(4'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        send(4'd4, 16'd5, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd3, 16'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        send(4'd7, 16'd2, 1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("abort");
        exp_q.delete();
        m_acc = 16'd0;
        m_hi = 16'd0;
        m_err = 3'd0;
        chain = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        send(4'd4, 16'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        send(4'd6, 16'd300, 1'b0, 1'b0, 32'd0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-level controller for the 16-bit ALU/accumulator datapath. It accepts one opcode plus a 16-bit operand per valid/ready handshake and owns the 16-bit accumulator. It drives the shared combinational ALU and holds its inputs stable for an opcode-dependent number of settle cycles, then writes back the result and accumulates sticky error flags. It sits between the instruction source (testbench or future fetch unit) and the ALU operation modules.

## Interface
- MUL_LAT, 2, EXEC cycles for multiply (legal 1..15)
- DIV_LAT, 4, EXEC cycles for divide and modulus (legal 1..15)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode; same encoding as the ALU channel map
- cmd_operand  in  16  operand A
- alu_a  out  16  latched operand to ALU
- alu_b  out  16  current accumulator to ALU
- alu_op  out  4  opcode to ALU; 0 outside EXEC
- alu_result  in  32  ALU result
- alu_ovf  in  1  ALU add/sub overflow
- acc  out  16  accumulator
- acc_hi  out  16  upper half of last multiply, else 0
- done  out  1  one-cycle pulse per completed command
- busy  out  1  state != IDLE
- err  out  3  sticky: [0] overflow, [1] divide-by-zero, [2] illegal opcode

## Operation
- Opcodes: 0 NOOP, 1 RESET (acc=0, acc_hi=0, err=0), 2 PRESET (acc=16'hFFFF, acc_hi=0), 3 illegal, 4 ADD, 5 SUB, 6 MUL, 7 DIV, 8 MOD, 9 AND, 10 OR, 11 XOR, 12 NOT, 13 NAND, 14 NOR, 15 XNOR.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op and operand and load the counter with L(op). Go to EXEC.
- L(op): 6 -> MUL_LAT; 7, 8 -> DIV_LAT; all others -> 1.
- EXEC: alu_a=latched operand, alu_b=acc, alu_op=latched op, all stable. The counter decrements each edge. On the edge where counter==1, perform writeback and go to DONE.
- Writeback by opcode:
  - 4, 5, 9..15: acc=alu_result[15:0], acc_hi=0.
  - 6: acc=alu_result[15:0], acc_hi=alu_result[31:16].
  - 7, 8 with operand!=0: as the arithmetic case above.
  - 7, 8 with operand==0: acc and acc_hi unchanged, err[1] set.
  - 0: no change.
  - 1, 2: as listed above.
  - 3: no change, err[2] set.
- err[0] is set if alu_ovf=1 at writeback and op is 4 or 5. alu_ovf is ignored for all other ops.
- err bits are sticky. They clear only on rst or opcode 1. Opcode 1 clears err even if a bit would otherwise set that cycle.
- DONE: done=1 for exactly one cycle, cmd_ready=0. Next state is IDLE.
- cmd_valid while not ready is ignored. The source holds the command until accepted.

## Timing
- Reset (rst low, asynchronous): state=IDLE, acc=0, acc_hi=0, err=0, done=0, busy=0, alu_a=0, alu_op=0. cmd_ready=1 once rst is high.
- Reset mid-command aborts the command with no writeback and no done.
- Latency: acceptance edge at T. EXEC spans L cycles, writeback at edge T+L, done high during cycle T+L+1. The next acceptance is possible at edge T+L+2.
- Throughput: one command per L+2 cycles.
- acc and err update only on the writeback edge. They stay stable through DONE and IDLE.
- The counter is 4 bits. Parameters outside 1..15 are a static error, flagged by elaboration-time check.

## Structure
- Shared package: opcode localparams (OP_NOOP..OP_XNOR), state encoding (IDLE/EXEC/DONE), error-bit indices, and the latency-select function L(op).
- Single module. The latency counter is kept inline, with no sub-module.
- The existing accumulator flip-flop moves into this block. The datapath keeps only the combinational operation modules.

## Test plan
- Reset, then ADD operand 12 with acc preloaded to 10 via PRESET/ALU path (ALU model returns 22) -> done at T+2, acc=22, err=0.
- MUL operand 20, acc=20, MUL_LAT=2 (model returns 400) -> busy for 3 cycles, done at T+3, acc=400, acc_hi=0. A 32'h0001_0000 result gives acc=0, acc_hi=1.
- DIV with operand 0, acc=20 -> acc stays 20, err=3'b010. A following NOOP leaves err=3'b010. A following RESET gives acc=0, err=0.
- SUB with alu_ovf=1 -> err[0]=1. A following AND with alu_ovf=1 adds no new error bits. Opcode 3 -> err=3'b101, acc unchanged.
- Back-to-back handshake: cmd_valid held high with two commands -> second accepted exactly at T+L+2. cmd_ready=0 throughout EXEC and DONE.
- rst asserted during DIV EXEC with DIV_LAT=4 -> outputs zero immediately, no done pulse, first command after release accepted normally.
